// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: register index, scoreboard shadow slot and its depth.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef struct packed {
        logic     valid;
        regbits_t dest;
        logic     load;
    } sb_slot_t;

    localparam int SB_DEPTH = 3;

endpackage

// File: rtl/sb_shadow_pipe.sv
// Shadow of the EX/MEM/WB destination registers; advances with the pipeline.
module sb_shadow_pipe
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     en,
    input  logic     flush,
    input  logic     issue_fire,
    input  regbits_t issue_dest,
    input  logic     issue_load,
    output sb_slot_t ex_slot,
    output logic     wb_valid,
    output regbits_t wb_dest,
    output logic     any_valid
);

    sb_slot_t r_slot [DEPTH];
    sb_slot_t w_new;

    assign w_new = issue_fire ? {1'b1, issue_dest, issue_load} : '0;

    // A flushed EX entry is dropped instead of moving into MEM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= '0;
            end
        end else if (en) begin
            r_slot[0] <= w_new;
            for (int i = 1; i < DEPTH; i++) begin
                r_slot[i] <= (i == 1 && flush) ? '0 : r_slot[i-1];
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | r_slot[i].valid;
        end
    end

    assign ex_slot  = r_slot[0];
    assign wb_valid = r_slot[DEPTH-1].valid;
    assign wb_dest  = r_slot[DEPTH-1].dest;

endmodule

// File: rtl/reg_scoreboard.sv
// Producer-side register dependency tracker: per-register in-flight write
// counts plus the load-use stall derived from the shadow EX slot.
module reg_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int CNTW  = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        en,
    input  logic        flush,
    input  logic        issue_valid,
    input  logic        issue_wr,
    input  logic [4:0]  issue_dest,
    input  logic        issue_load,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    output logic        stall,
    output logic        busy_rs,
    output logic        busy_rt,
    output logic [31:0] pending,
    output logic        sb_empty
);

    sb_slot_t        w_ex_slot;
    logic            w_wb_valid;
    regbits_t        w_wb_dest;
    logic            w_any_valid;
    logic            w_stall;
    logic            w_issue_fire;
    logic            w_retire;
    logic            w_flush_dec;
    logic [CNTW-1:0] r_cnt [1:31];
    logic            w_up  [1:31];
    logic [1:0]      w_dn  [1:31];

    assign w_stall = w_ex_slot.valid && w_ex_slot.load && (w_ex_slot.dest != '0) &&
                     ((id_rs == w_ex_slot.dest) ||
                      (id_uses_rt && (id_rt == w_ex_slot.dest)));

    assign w_issue_fire = en && issue_valid && issue_wr && (issue_dest != '0) &&
                          !w_stall && !flush;
    assign w_retire     = en && w_wb_valid;
    assign w_flush_dec  = en && flush && w_ex_slot.valid;

    sb_shadow_pipe #(
        .DEPTH(DEPTH)
    ) u_shadow (
        .CLK        (CLK),
        .RST        (RST),
        .en         (en),
        .flush      (flush),
        .issue_fire (w_issue_fire),
        .issue_dest (issue_dest),
        .issue_load (issue_load),
        .ex_slot    (w_ex_slot),
        .wb_valid   (w_wb_valid),
        .wb_dest    (w_wb_dest),
        .any_valid  (w_any_valid)
    );

    // Net change per register: at most one increment, up to two decrements.
    function automatic logic [CNTW-1:0] f_next_cnt(input logic [CNTW-1:0] c,
                                                   input logic            up,
                                                   input logic [1:0]      dn);
        logic [1:0] sub;
        f_next_cnt = c;
        if (up && dn == 2'd0) begin
            if (c < CNTW'(DEPTH)) begin
                f_next_cnt = c + 1'b1;
            end
        end else begin
            sub        = dn - {1'b0, up};
            f_next_cnt = (c < CNTW'(sub)) ? '0 : c - CNTW'(sub);
        end
    endfunction

    always_comb begin
        for (int r = 1; r < 32; r++) begin
            w_up[r] = w_issue_fire && (issue_dest == 5'(r));
            w_dn[r] = {1'b0, w_retire && (w_wb_dest == 5'(r))} +
                      {1'b0, w_flush_dec && (w_ex_slot.dest == 5'(r))};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 1; r < 32; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                r_cnt[r] <= f_next_cnt(r_cnt[r], w_up[r], w_dn[r]);
            end
        end
    end

    always_comb begin
        pending    = '0;
        for (int r = 1; r < 32; r++) begin
            pending[r] = (r_cnt[r] != '0);
        end
    end

    assign stall    = w_stall;
    assign busy_rs  = pending[id_rs];
    assign busy_rt  = pending[id_rt];
    assign sb_empty = !w_any_valid;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed pipeline scenarios plus random traffic
// checked against an independent cycle model of the scoreboard.
module tb_reg_scoreboard;

    localparam int DEPTH = 3;
    localparam int VW    = 36;

    logic        CLK = 1'b0;
    logic        RST;
    logic        en, flush, issue_valid, issue_wr, issue_load, id_uses_rt;
    logic [4:0]  issue_dest, id_rs, id_rt;
    logic        stall, busy_rs, busy_rt, sb_empty;
    logic [31:0] pending;

    always #5 CLK = ~CLK;

    reg_scoreboard #(
        .DEPTH(3),
        .CNTW (2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .en          (en),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_dest  (issue_dest),
        .issue_load  (issue_load),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .stall       (stall),
        .busy_rs     (busy_rs),
        .busy_rt     (busy_rt),
        .pending     (pending),
        .sb_empty    (sb_empty)
    );

    int             n_vec = 0;
    int             n_err = 0;
    int             n_ovf = 0;
    int             n_unf = 0;
    logic [VW-1:0]  exp_q[$];

    // Reference model state
    int             m_cnt [32];
    logic           m_v   [3];
    logic [4:0]     m_d   [3];
    logic           m_l   [3];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        for (int s = 0; s < 3; s++) begin
            m_v[s] = 1'b0;
            m_d[s] = '0;
            m_l[s] = 1'b0;
        end
    endtask

    function automatic logic m_stall();
        return m_v[0] && m_l[0] && (m_d[0] != 0) &&
               ((id_rs == m_d[0]) || (id_uses_rt && (id_rt == m_d[0])));
    endfunction

    function automatic logic [VW-1:0] m_outputs();
        logic [31:0] p;
        p = '0;
        for (int r = 1; r < 32; r++) p[r] = (m_cnt[r] != 0);
        return {m_stall(), p[id_rs], p[id_rt], !(m_v[0] | m_v[1] | m_v[2]), p};
    endfunction

    // Advance the model by one enabled clock edge.
    task automatic m_update();
        int   delta [32];
        int   nv;
        logic fire;
        fire = issue_valid && issue_wr && (issue_dest != 0) && !m_stall() && !flush;
        for (int r = 0; r < 32; r++) delta[r] = 0;
        if (fire) delta[issue_dest] += 1;
        if (m_v[2]) delta[m_d[2]] -= 1;
        if (flush && m_v[0]) delta[m_d[0]] -= 1;
        for (int r = 1; r < 32; r++) begin
            nv = m_cnt[r] + delta[r];
            if (nv > DEPTH) begin n_ovf++; nv = DEPTH; end
            if (nv < 0) begin n_unf++; nv = 0; end
            m_cnt[r] = nv;
        end
        m_v[2] = m_v[1]; m_d[2] = m_d[1]; m_l[2] = m_l[1];
        m_v[1] = flush ? 1'b0 : m_v[0];
        m_d[1] = m_d[0]; m_l[1] = m_l[0];
        m_v[0] = fire; m_d[0] = issue_dest; m_l[0] = issue_load;
    endtask

    task automatic drive(input logic e, input logic f, input logic iv, input logic iw,
                         input logic [4:0] dst, input logic ld, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt);
        en = e; flush = f; issue_valid = iv; issue_wr = iw; issue_dest = dst;
        issue_load = ld; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    endtask

    // One pipeline cycle: expected outputs queued from the model, compared
    // mid-cycle, then the model follows the DUT across the edge.
    task automatic step(input string tag, input logic e, input logic f, input logic iv,
                        input logic iw, input logic [4:0] dst, input logic ld,
                        input logic [4:0] rs, input logic [4:0] rt, input logic urt);
        logic [VW-1:0] got;
        drive(e, f, iv, iw, dst, ld, rs, rt, urt);
        @(negedge CLK);
        exp_q.push_back(m_outputs());
        got = {stall, busy_rs, busy_rt, sb_empty, pending};
        chk(tag, got, exp_q.pop_front());
        if (e) m_update();
        @(posedge CLK);
        #1;
    endtask

    task automatic bubble(input string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        RST = 1'b1;
        m_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_pending", pending, 32'h0);
        chk("rst_empty", sb_empty, 1'b1);
        chk("rst_stall", stall, 1'b0);
        // Reset wins over an issue presented at the same edge
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 1'b0);
        @(posedge CLK);
        #1;
        chk("rst_prio_pending", pending, 32'h0);
        chk("rst_prio_empty", sb_empty, 1'b1);
        RST = 1'b0;

        // ADD $3 travels the pipe and retires after three more edges
        step("add3", 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 1'b0);
        chk("add3_pending", pending, 32'h8);
        chk("add3_empty", sb_empty, 1'b0);
        repeat (3) bubble("add3_drain");
        chk("add3_done_pending", pending, 32'h0);
        chk("add3_done_empty", sb_empty, 1'b1);

        // LW $5 followed by ADD $6,$5,$2
        step("lw5", 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 5'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 5'd5, 5'd2, 1'b1);
        #1;
        chk("lu_stall_on", stall, 1'b1);
        step("lu_stall", 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 5'd5, 5'd2, 1'b1);
        chk("lu_stall_off", stall, 1'b0);
        chk("lu_busy_rs", busy_rs, 1'b1);
        step("lu_issue", 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 5'd5, 5'd2, 1'b1);
        repeat (4) step("lu_drain", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd6, 1'b1);

        // Store reading the load result through rt only
        step("lw5_b", 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 5'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 1'b1);
        #1;
        chk("sw_rt_stall", stall, 1'b1);
        step("sw_rt", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 1'b0);
        #1;
        chk("sw_nort_stall", stall, 1'b0);
        step("sw_nort", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 1'b0);
        repeat (4) bubble("sw_drain");

        // Three back-to-back writes of $7
        repeat (3) begin
            step("w7_issue", 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd7, 5'd0, 1'b0);
            chk("w7_pending", pending[7], 1'b1);
        end
        repeat (2) bubble("w7_drain");
        chk("w7_mid", pending[7], 1'b1);
        bubble("w7_drain");
        chk("w7_done", pending[7], 1'b0);

        // ORI $9 squashed by a flush; the ID instruction ($10) is suppressed
        step("ori9", 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0, 1'b0);
        step("flush9", 1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0, 5'd9, 5'd10, 1'b1);
        chk("flush_pending", pending, 32'h0);
        chk("flush_empty", sb_empty, 1'b1);
        repeat (3) step("flush_drain", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd10, 1'b1);

        // Pipe frozen with LW $4 in EX and a consumer in ID
        step("lw4", 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b1, 5'd0, 5'd0, 1'b0);
        repeat (4) begin
            step("freeze", 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd4, 5'd1, 1'b1);
            chk("freeze_stall", stall, 1'b1);
            chk("freeze_pending", pending, 32'h10);
        end
        step("unfreeze", 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd4, 5'd1, 1'b1);
        chk("unfreeze_stall", stall, 1'b0);
        repeat (5) bubble("unfreeze_drain");

        // Random traffic over a small register set to provoke collisions
        for (int k = 0; k < 400; k++) begin
            step("rand",
                 1'($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)));
        end
        repeat (4) bubble("final_drain");
        chk("final_empty", sb_empty, 1'b1);
        chk("no_overflow", n_ovf, 0);
        chk("no_underflow", n_unf, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Producer-side register dependency tracker for the 5-stage MIPS pipeline. It records every in-flight register write from issue (ID→EX) through retirement (end of WB). It keeps a per-register pending count and a shadow pipe of destination registers that mirrors EX/MEM/WB. From these it drives the load-use stall and per-source busy flags. It sits beside the hazard/forwarding logic in the datapath: forwarding consumes results, and this block accounts for who will produce them.

## Interface
Parameters:
- DEPTH, 3: number of shadow stages (EX, MEM, WB)
- CNTW, 2: width of each per-register pending counter; must hold 0..DEPTH

Ports:
- CLK  in  1  pipeline clock, rising edge
- RST  in  1  reset, synchronous, active-high
- en  in  1  pipeline advance (low while the cache or memory holds the pipe); when low, all state holds
- flush  in  1  squash the instructions in ID and EX (branch/jump taken)
- issue_valid  in  1  ID holds a real instruction
- issue_wr  in  1  ID instruction writes a register
- issue_dest  in  5  ID destination register
- issue_load  in  1  ID instruction is LW/LL
- id_rs, id_rt  in  5 each  ID source registers
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, SW, BEQ/BNE)
- stall  out  1  hold PC and IF/ID, insert a bubble into EX
- busy_rs, busy_rt  out  1 each  the source register has a nonzero pending count
- pending  out  32  bit r = (cnt[r] != 0); bit 0 always 0
- sb_empty  out  1  no valid shadow slot

## Operation
- State: cnt[1..31] of width CNTW. The shadow pipe slots EX, MEM, WB each hold {valid, dest, load}.
- Issue fires when en && issue_valid && issue_wr && issue_dest != 0 && !stall && !flush. The EX slot loads {1, issue_dest, issue_load} and cnt[issue_dest]++. When en is high and issue does not fire, the EX slot loads invalid.
- On en, the slots shift: EX→MEM, MEM→WB.
- Retire fires when en && WB.valid. It decrements cnt[WB.dest].
- Flush (with en) invalidates the current EX slot before the shift and decrements cnt[EX.dest] if that slot is valid. MEM and WB are unaffected. Flush suppresses issue in the same cycle.
- Simultaneous events on the same register combine as a net change: issue +1, retire −1, flush −1, applied in one update. Issue with retire gives no change. Retire with flush gives −2.
- stall = EX.valid && EX.load && EX.dest != 0 && (id_rs == EX.dest || (id_uses_rt && id_rt == EX.dest)). This is the load-use case. All other RAW cases are covered by forwarding.
- Register 0 is never counted, never busy, and never causes a stall.
- Overflow (cnt == DEPTH and an increment) cannot occur by construction. The bench asserts it. The RTL saturates the count and does not wrap.
- Underflow (a decrement at cnt == 0) is an error. The bench asserts it. The RTL clamps at 0.

## Timing
- Reset: all cnt = 0 and all slots invalid. Therefore stall = 0, busy_* = 0, pending = 0, sb_empty = 1. RST takes priority over en, flush and issue.
- stall, busy_*, pending and sb_empty are combinational from registered state and the current ID inputs. There is no added latency.
- With en held high, an instruction issued at edge t is in EX during cycle t..t+1, MEM at t+1..t+2 and WB at t+2..t+3. It retires at edge t+3, and pending clears from t+3.
- A load-use stall lasts exactly one cycle when en is high. The next edge moves the load into MEM, where MEM→EX forwarding applies.
- While en is low, stall stays stable and reflects the frozen EX slot.

## Structure
- Add to cpu_types_pkg:
  - typedef sb_slot_t = struct packed {logic valid; regbits_t dest; logic load;}
  - localparam SB_DEPTH = 3
- Sub-module sb_shadow_pipe: the DEPTH-slot shift register with the en, flush and issue inputs. It outputs the EX and WB slots to the counter logic in reg_scoreboard.

## Test plan
- Reset with RST=1 for 2 cycles, then issue ADD $3 → pending = 0x8, sb_empty = 0. After 3 further en edges → pending = 0, sb_empty = 1.
- LW $5, then ADD $6,$5,$2 in ID → stall = 1 for exactly 1 cycle. Then stall = 0 and busy_rs = 1 until the LW retires.
- LW $5 in EX, SW with rs=$0 and rt=$5 (id_uses_rt=1) → stall = 1. The same case with id_uses_rt=0 → stall = 0.
- Three back-to-back writes to $7 → cnt[7] goes 1, 2, 3, then falls by 1 per edge. No overflow assertion fires.
- Issue ORI $9 then flush on the next edge → cnt[9] returns to 0 one edge later. No retire of $9 occurs in WB.
- en low for 4 cycles with LW $4 in EX and a consumer of $4 in ID → stall stays 1 and no state changes. After en rises, stall drops one edge later.
